// File: rtl/soc_system_pio_cmd_out.sv
// Avalon-MM output PIO that presents a command byte to fabric with a valid/ack handshake.
// A command is held stable on out_port while out_valid is high. Writes that arrive while a command is pending are dropped and flagged as overrun.
module soc_system_pio_cmd_out #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  chipselect,
  input  logic [1:0]            address,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_valid,
  input  logic                  out_ack
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_STATUS   = 2'd1;
  localparam logic [1:0] ADDR_OUTSET   = 2'd2;
  localparam logic [1:0] ADDR_OUTCLEAR = 2'd3;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_port_q, out_port_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            ack_cnt_q, ack_cnt_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  wr_en;
  logic                  launch_req;
  logic                  status_clr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  unused_writedata;

  assign wr_en      = chipselect & ~write_n;
  assign launch_req = wr_en & (address != ADDR_STATUS);
  assign status_clr = wr_en & (address == ADDR_STATUS) & writedata[1];
  assign wr_data    = writedata[DATA_WIDTH-1:0];

  // Upper data bits have no meaning for this port width.
  assign unused_writedata = ^writedata[31:DATA_WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      out_port_q <= RESET_VALUE;
      overrun_q  <= 1'b0;
      ack_cnt_q  <= 8'd0;
      readdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      out_port_q <= out_port_d;
      overrun_q  <= overrun_d;
      ack_cnt_q  <= ack_cnt_d;
      readdata_q <= readdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    out_port_d = out_port_q;
    overrun_d  = overrun_q;
    ack_cnt_d  = ack_cnt_q;

    case (state_q)
      IDLE: begin
        if (launch_req) begin
          state_d = PEND;
          case (address)
            ADDR_DATA:     out_port_d = wr_data;
            ADDR_OUTSET:   out_port_d = out_port_q | wr_data;
            ADDR_OUTCLEAR: out_port_d = out_port_q & ~wr_data;
            default:       out_port_d = out_port_q;
          endcase
        end
      end
      PEND: begin
        // An ack arriving alongside a write still completes the transfer, but the write is lost.
        if (launch_req) begin
          overrun_d = 1'b1;
        end
        if (out_ack) begin
          state_d   = IDLE;
          ack_cnt_d = ack_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (status_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Reads are registered from the current (pre-write) register values.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = out_port_q;
      ADDR_STATUS: begin
        readdata_d[0]    = (state_q == PEND);
        readdata_d[1]    = overrun_q;
        readdata_d[15:8] = ack_cnt_q;
      end
      default: readdata_d = 32'd0;
    endcase
  end

  assign readdata  = readdata_q;
  assign out_port  = out_port_q;
  assign out_valid = (state_q == PEND);

endmodule

// File: tb/tb_soc_system_pio_cmd_out.sv
// Directed testbench for soc_system_pio_cmd_out with DATA_WIDTH=8 and RESET_VALUE=0.
// Inputs change and outputs are sampled on the falling edge; the DUT registers on the rising edge.
module tb_soc_system_pio_cmd_out;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
  logic        out_valid;
  logic        out_ack;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  soc_system_pio_cmd_out #(
    .DATA_WIDTH (8),
    .RESET_VALUE(8'h00)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic cs, input logic [1:0] addr, input logic wn,
                               input logic [31:0] wd, input logic ack);
    chipselect = cs;
    address    = addr;
    write_n    = wn;
    writedata  = wd;
    out_ack    = ack;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One-cycle write strobe, then bus returns to idle with the address held.
  task automatic doWrite(input logic [1:0] addr, input logic [31:0] wd);
    applyStimulus(1'b1, addr, 1'b0, wd, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, addr, 1'b1, 32'd0, 1'b0);
  endtask

  task automatic doAck();
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  task automatic readReg(input string tag, input logic [1:0] addr, input logic [31:0] expected);
    applyStimulus(1'b0, addr, 1'b1, 32'd0, 1'b0);
    @(negedge clk);
    checkOutput(tag, readdata, expected);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b1, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_out_port", {24'd0, out_port}, 32'h00);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_readdata", readdata, 32'd0);
    reset_n = 1'b1;

    for (int a = 0; a < 4; a++) begin
      readReg($sformatf("rst_read_addr%0d", a), 2'(a), 32'd0);
    end

    // Single transfer held for five cycles before the ack.
    doWrite(2'd0, 32'h0000_00A5);
    checkOutput("a5_out_port", {24'd0, out_port}, 32'hA5);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("a5_valid_hold%0d", c), {31'd0, out_valid}, 32'd1);
      if (c < 4) @(negedge clk);
    end
    doAck();
    exp_cnt++;
    checkOutput("a5_valid_drop", {31'd0, out_valid}, 32'd0);
    readReg("a5_status", 2'd1, 32'h0000_0100);

    // DATA, OUTSET and OUTCLEAR each launch a transfer.
    doWrite(2'd0, 32'hFFFF_FF0F);
    checkOutput("data_0f", {24'd0, out_port}, 32'h0F);
    doAck();
    doWrite(2'd2, 32'h0000_00F0);
    checkOutput("outset_ff", {24'd0, out_port}, 32'hFF);
    checkOutput("outset_valid", {31'd0, out_valid}, 32'd1);
    doAck();
    doWrite(2'd3, 32'h0000_003C);
    checkOutput("outclear_c3", {24'd0, out_port}, 32'hC3);
    doAck();
    exp_cnt += 3;
    readReg("mode_status", 2'd1, 32'h0000_0400);
    readReg("outset_read0", 2'd2, 32'd0);
    readReg("outclear_read0", 2'd3, 32'd0);
    readReg("data_read_c3", 2'd0, 32'h0000_00C3);

    // Write colliding with the ack in PEND.
    doWrite(2'd0, 32'h11);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h22, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'd0, 1'b0);
    exp_cnt++;
    checkOutput("collide_out_port", {24'd0, out_port}, 32'h11);
    checkOutput("collide_valid", {31'd0, out_valid}, 32'd0);
    readReg("collide_status", 2'd1, 32'h0000_0502);
    doWrite(2'd1, 32'h2);
    checkOutput("w1c_no_launch", {31'd0, out_valid}, 32'd0);
    readReg("w1c_status", 2'd1, 32'h0000_0500);

    // Plain overrun while the command waits for its ack.
    doWrite(2'd0, 32'h33);
    doWrite(2'd0, 32'h44);
    checkOutput("overrun_hold", {24'd0, out_port}, 32'h33);
    readReg("overrun_busy_status", 2'd1, 32'h0000_0503);
    doAck();
    exp_cnt++;
    readReg("overrun_status", 2'd1, 32'h0000_0602);
    doWrite(2'd1, 32'h2);
    readReg("overrun_cleared", 2'd1, 32'h0000_0600);

    // Fresh reset, then 256 transfers to wrap the counter.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 255; i++) begin
      doWrite(2'd0, 32'(i));
      doAck();
    end
    readReg("cnt_255", 2'd1, 32'h0000_FF00);
    doWrite(2'd0, 32'h0000_01FF);
    doAck();
    readReg("cnt_wrap", 2'd1, 32'h0000_0000);
    checkOutput("wrap_out_port", {24'd0, out_port}, 32'hFF);
    repeat (3) doAck();
    readReg("idle_ack_ignored", 2'd1, 32'h0000_0000);
    checkOutput("idle_ack_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a pending transfer.
    doWrite(2'd0, 32'h5A);
    checkOutput("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_out_port", {24'd0, out_port}, 32'h00);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h77, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'd0, 1'b0);
    checkOutput("read_pre_write", readdata, 32'h00);
    checkOutput("post_rst_out_port", {24'd0, out_port}, 32'h77);
    checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    checkOutput("read_post_write", readdata, 32'h77);
    doAck();
    checkOutput("post_rst_ack", {31'd0, out_valid}, 32'd0);
    readReg("post_rst_status", 2'd1, 32'h0000_0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
